// File: rtl/rr_tdm_arb.sv
// Round-robin N-master arbiter with per-master programmable time slices.
// Grants are registered; s_act and slice_done are derived from the registers and req.
module rr_tdm_arb #(
    parameter int unsigned N         = 4,
    parameter int unsigned QW        = 4,
    parameter bit          EARLY_REL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N-1:0]                  req,
    input  logic [N*QW-1:0]               quantum,
    output logic [N-1:0]                  gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
    output logic                          gnt_vld,
    output logic                          s_act,
    output logic                          slice_done
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_ptr;
    logic [QW-1:0]   cnt;
    logic [QW-1:0]   q_lat;

    logic [IW-1:0]   base;
    logic            found;
    logic [IW-1:0]   sel;
    logic [QW-1:0]   q_sel;
    logic [QW-1:0]   q_eff;
    logic [N-1:0]    sel_onehot;
    logic            slice_end;

    // Rotating search from base+1; base itself comes last, which gives the
    // re-grant of the current owner its lowest priority at a slice end.
    always_comb begin
        base  = (state == IDLE) ? last_ptr : gnt_id;
        found = 1'b0;
        sel   = '0;
        q_sel = '0;
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = int'(base) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                sel   = IW'(idx);
                q_sel = quantum[idx*int'(QW) +: QW];
            end
        end
        q_eff      = (q_sel == '0) ? QW'(1) : q_sel;
        sel_onehot = N'(1) << sel;
    end

    always_comb begin
        slice_end = 1'b0;
        if (state == GRANT) begin
            slice_end = (cnt == (q_lat - QW'(1))) || (EARLY_REL && !req[gnt_id]);
        end
    end

    assign slice_done = slice_end;
    assign s_act      = gnt_vld & req[gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            cnt      <= '0;
            q_lat    <= QW'(1);
            last_ptr <= IW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        gnt     <= sel_onehot;
                        gnt_id  <= sel;
                        gnt_vld <= 1'b1;
                        cnt     <= '0;
                        q_lat   <= q_eff;
                    end
                end
                GRANT: begin
                    if (slice_end) begin
                        last_ptr <= gnt_id;
                        cnt      <= '0;
                        if (found) begin
                            gnt    <= sel_onehot;
                            gnt_id <= sel;
                            q_lat  <= q_eff;
                        end else begin
                            state   <= IDLE;
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + QW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
